// File: rtl/dps_responder.sv
// DCM-side model of the digital phase shift handshake: emulated lock after reset,
// fixed-latency psdone for each accepted psen, and a saturating signed phase offset.
module dps_responder #(
   parameter int LOCK_DLY = 16,
   parameter int DPS_LAT  = 8,
   parameter int PH_MIN   = -32,
   parameter int PH_MAX   = 31,
   parameter int PH_W     = 7
) (
   input  logic            clock,
   input  logic            global_reset_n,
   input  logic            dcm_rst,
   input  logic            psen,
   input  logic            psincdec,
   output logic            psdone,
   output logic            lock_dcm,
   output logic [PH_W-1:0] phase_ofs,
   output logic            ps_overflow,
   output logic            busy,
   output logic [1:0]      dps_sm_vec,
   output logic            err_psen
);

   typedef enum logic [1:0] {LOCKING = 2'd0, READY = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

   localparam int LW = $clog2(LOCK_DLY + 1);
   localparam int CW = (DPS_LAT > 2) ? $clog2(DPS_LAT) : 1;
   localparam logic [PH_W-1:0] PMAX = PH_W'(PH_MAX);
   localparam logic [PH_W-1:0] PMIN = PH_W'(PH_MIN);

   state_t          state;
   logic [LW-1:0]   lock_cnt;
   logic [CW-1:0]   lat_cnt;
   logic            dir;

   assign dps_sm_vec = state;

   always_ff @(posedge clock) begin
      if (!global_reset_n || dcm_rst) begin
         state       <= LOCKING;
         lock_cnt    <= '0;
         lat_cnt     <= '0;
         dir         <= 1'b0;
         lock_dcm    <= 1'b0;
         psdone      <= 1'b0;
         phase_ofs   <= '0;
         ps_overflow <= 1'b0;
         busy        <= 1'b0;
         // dcm_rst alone keeps the sticky protocol error visible
         if (!global_reset_n)
            err_psen <= 1'b0;
      end else begin
         case (state)
            LOCKING: begin
               if (psen)
                  err_psen <= 1'b1;
               if (lock_cnt == LW'(LOCK_DLY - 1)) begin
                  state    <= READY;
                  lock_dcm <= 1'b1;
               end else begin
                  lock_cnt <= lock_cnt + 1'b1;
               end
            end
            READY: begin
               if (psen) begin
                  dir     <= psincdec;
                  lat_cnt <= CW'(DPS_LAT - 2);
                  state   <= SHIFT;
                  busy    <= 1'b1;
               end
            end
            SHIFT: begin
               if (psen)
                  err_psen <= 1'b1;
               if (lat_cnt == '0) begin
                  state  <= DONE;
                  psdone <= 1'b1;
                  // saturate at the inclusive limits, flagging the refused step
                  if ((dir && phase_ofs == PMAX) || (!dir && phase_ofs == PMIN)) begin
                     ps_overflow <= 1'b1;
                  end else begin
                     ps_overflow <= 1'b0;
                     phase_ofs   <= dir ? phase_ofs + 1'b1 : phase_ofs - 1'b1;
                  end
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            DONE: begin
               if (psen)
                  err_psen <= 1'b1;
               psdone <= 1'b0;
               busy   <= 1'b0;
               state  <= READY;
            end
            default: state <= LOCKING;
         endcase
      end
   end

endmodule

// File: tb/tb_dps_responder.sv
// Directed bench for dps_responder: lock timing, shift handshake latency,
// phase saturation via a vector table, and psen/dcm_rst corner sequences.
module tb_dps_responder;

   logic       clock = 1'b0;
   logic       global_reset_n, dcm_rst, psen, psincdec;
   logic       psdone, lock_dcm, ps_overflow, busy, err_psen;
   logic [6:0] phase_ofs;
   logic [1:0] dps_sm_vec;

   int checks = 0;
   int errors = 0;

   dps_responder dut (
      .clock(clock), .global_reset_n(global_reset_n), .dcm_rst(dcm_rst),
      .psen(psen), .psincdec(psincdec), .psdone(psdone), .lock_dcm(lock_dcm),
      .phase_ofs(phase_ofs), .ps_overflow(ps_overflow), .busy(busy),
      .dps_sm_vec(dps_sm_vec), .err_psen(err_psen)
   );

   always #12 clock = ~clock;

   typedef struct {
      logic       dir;
      int         count;
      logic [6:0] exp_phase;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs[8];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issues one psen at edge t and checks psdone/busy across cycles t+1..t+8 and after.
   task automatic do_shift(input logic d);
      int bad;
      bad = 0;
      psen = 1'b1; psincdec = d;
      step();
      psen = 1'b0; psincdec = ~d;
      for (int k = 1; k <= 8; k++) begin
         if (busy !== 1'b1 || psdone !== (k == 8)) bad++;
         step();
      end
      if (psdone !== 1'b0 || busy !== 1'b0 || dps_sm_vec !== 2'd1) bad++;
      check("shift_handshake", bad, 0);
   endtask

   task automatic check_relock(input string name);
      int bad;
      bad = 0;
      for (int k = 1; k <= 16; k++) begin
         step();
         if (lock_dcm !== (k == 16)) bad++;
         if (psdone !== 1'b0) bad++;
      end
      check(name, bad, 0);
      check({name, "_state"}, dps_sm_vec, 2'd1);
   endtask

   initial begin
      int pd;
      logic [6:0] ph0;
      vecs[0] = '{1'b1, 1,  7'd1,   1'b0};
      vecs[1] = '{1'b1, 30, 7'd31,  1'b0};
      vecs[2] = '{1'b1, 1,  7'd31,  1'b1};
      vecs[3] = '{1'b0, 1,  7'd30,  1'b0};
      vecs[4] = '{1'b0, 30, 7'd0,   1'b0};
      vecs[5] = '{1'b0, 32, 7'h60,  1'b0};
      vecs[6] = '{1'b0, 1,  7'h60,  1'b1};
      vecs[7] = '{1'b1, 1,  7'h61,  1'b0};

      global_reset_n = 1'b0; dcm_rst = 1'b0; psen = 1'b0; psincdec = 1'b0;
      repeat (3) step();
      check("rst_lock", lock_dcm, 0);
      check("rst_phase", phase_ofs, 0);
      check("rst_psdone", psdone, 0);
      check("rst_state", dps_sm_vec, 0);
      check("rst_err", err_psen, 0);
      check("rst_busy_ovf", {busy, ps_overflow}, 0);

      global_reset_n = 1'b1;
      check_relock("lock_after_reset");

      for (int i = 0; i < 8; i++) begin
         for (int n = 0; n < vecs[i].count; n++) do_shift(vecs[i].dir);
         check($sformatf("vec%0d_phase", i), phase_ofs, vecs[i].exp_phase);
         check($sformatf("vec%0d_ovf", i), ps_overflow, vecs[i].exp_ovf);
      end
      check("err_clean", err_psen, 0);

      // second psen at t+3 during SHIFT
      ph0 = phase_ofs; pd = 0;
      psen = 1'b1; psincdec = 1'b1;
      step();
      psen = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         if (k == 3) psen = 1'b1;
         if (psdone) pd++;
         if (k == 8) check("repeat_psdone_at_t8", psdone, 1);
         step();
         psen = 1'b0;
      end
      check("repeat_single_psdone", pd, 1);
      check("repeat_phase", phase_ofs, ph0 + 7'd1);
      check("repeat_err", err_psen, 1);

      // dcm_rst mid-shift
      pd = 0;
      psen = 1'b1; psincdec = 1'b1;
      step();
      psen = 1'b0;
      repeat (3) begin
         if (psdone) pd++;
         step();
      end
      dcm_rst = 1'b1;
      step();
      check("dcmrst_lock", lock_dcm, 0);
      check("dcmrst_phase", phase_ofs, 0);
      check("dcmrst_state", dps_sm_vec, 0);
      check("dcmrst_err_kept", err_psen, 1);
      repeat (4) begin
         if (psdone) pd++;
         step();
      end
      dcm_rst = 1'b0;
      check_relock("relock_after_dcm_rst");
      check("dcmrst_no_psdone", pd, 0);
      check("dcmrst_phase_after", phase_ofs, 0);

      global_reset_n = 1'b0;
      step();
      check("err_cleared_by_reset", err_psen, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
